dmem_responder: RTL and testbench

Data-memory responder for the pipelined core's load/store path: accepts one doubleword read or write request at a time over a valid/ready handshake and returns a response after a configurable number of wait states. It sits between the core's MEM stage (initiator) and the on-chip data storage. It replaces the zero-latency array so that the pipeline's stall logic can be exercised against a slow memory. It also reports decode errors and keeps saturating access counters for debug.

---
 rtl/dmem_pkg.sv | 19 +
 rtl/dmem_array.sv | 27 ++
 rtl/dmem_responder.sv | 132 +++++++++++++
 tb/tb_dmem_responder.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and widths for the data-memory responder.
package dmem_pkg;

    localparam int DMEM_DATA_W = 64;
    localparam int DMEM_ADDR_W = 32;
    localparam int DMEM_CNT_W  = 16;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } dmem_state_t;

    // Debug counters stick at all-ones instead of wrapping.
    function automatic logic [DMEM_CNT_W-1:0] sat_inc(input logic [DMEM_CNT_W-1:0] v);
        return (&v) ? v : v + DMEM_CNT_W'(1);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Doubleword storage: synchronous write, combinational read, no reset.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int   WORDS = 256,
    localparam int  IDX_W = $clog2(WORDS)
) (
    input  logic                   clk,
    input  logic                   we,
    input  logic [IDX_W-1:0]       waddr,
    input  logic [DMEM_DATA_W-1:0] wdata,
    input  logic [IDX_W-1:0]       raddr,
    output logic [DMEM_DATA_W-1:0] rdata
);

    logic [DMEM_DATA_W-1:0] mem [WORDS];

    // NOTE: storage arrays get no reset; clearing them would need a write port per word.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding load/store responder with programmable wait states,
// decode-error reporting and saturating access counters.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int MEM_WORDS   = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_write,
    input  logic [DMEM_ADDR_W-1:0] req_addr,
    input  logic [DMEM_DATA_W-1:0] req_wdata,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [DMEM_DATA_W-1:0] rsp_rdata,
    output logic                   rsp_error,
    output logic [DMEM_CNT_W-1:0]  rd_count,
    output logic [DMEM_CNT_W-1:0]  wr_count
);

    localparam int IDX_W = $clog2(MEM_WORDS);
    localparam logic [DMEM_ADDR_W-4:0] WORD_LIMIT = (DMEM_ADDR_W-3)'(MEM_WORDS);

    dmem_state_t            state_q;
    logic [3:0]             cnt_q;
    logic [DMEM_ADDR_W-1:0] addr_q;
    logic                   write_q;
    logic [DMEM_DATA_W-1:0] wdata_q;
    logic [DMEM_CNT_W-1:0]  rd_cnt_q;
    logic [DMEM_CNT_W-1:0]  wr_cnt_q;

    logic                   accept;
    logic                   commit;
    logic [DMEM_ADDR_W-1:0] c_addr;
    logic                   c_write;
    logic [DMEM_DATA_W-1:0] c_wdata;
    logic                   c_error;
    logic [IDX_W-1:0]       c_idx;
    logic                   mem_we;
    logic [DMEM_DATA_W-1:0] rd_word;

    assign accept = (state_q == IDLE) && req_valid;
    assign commit = (accept && (WAIT_STATES == 0)) ||
                    ((state_q == WAIT) && (cnt_q == 4'd1));

    // With zero wait states the commit edge is the accept edge, so the
    // request comes straight from the port rather than from the latches.
    assign c_addr  = (state_q == IDLE) ? req_addr  : addr_q;
    assign c_write = (state_q == IDLE) ? req_write : write_q;
    assign c_wdata = (state_q == IDLE) ? req_wdata : wdata_q;

    assign c_error = (c_addr[2:0] != 3'd0) || (c_addr[DMEM_ADDR_W-1:3] >= WORD_LIMIT);
    assign c_idx   = c_addr[3 +: IDX_W];
    assign mem_we  = rst && commit && c_write && !c_error;

    dmem_array #(
        .WORDS (MEM_WORDS)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .waddr (c_idx),
        .wdata (c_wdata),
        .raddr (c_idx),
        .rdata (rd_word)
    );

    // NOTE: every register here is assigned with <=, so all reads within the block see pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_error <= 1'b0;
            cnt_q     <= '0;
            addr_q    <= '0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            rd_cnt_q  <= '0;
            wr_cnt_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        addr_q    <= req_addr;
                        write_q   <= req_write;
                        wdata_q   <= req_wdata;
                        cnt_q     <= 4'(WAIT_STATES);
                        req_ready <= 1'b0;
                        state_q   <= WAIT;
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state_q   <= IDLE;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                end
            endcase

            if (commit) begin
                state_q   <= RESP;
                rsp_valid <= 1'b1;
                req_ready <= 1'b0;
                rsp_error <= c_error;
                rsp_rdata <= (c_error || c_write) ? '0 : rd_word;
                if (!c_error && c_write) begin
                    wr_cnt_q <= sat_inc(wr_cnt_q);
                end
                if (!c_error && !c_write) begin
                    rd_cnt_q <= sat_inc(rd_cnt_q);
                end
            end
        end
    end

    assign rd_count = rd_cnt_q;
    assign wr_count = wr_cnt_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboarded bench for dmem_responder at two wait-state settings.
module tb_dmem_responder;

    localparam int WS = 2;

    typedef struct {
        logic [63:0] rdata;
        logic        err;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr;
    logic [63:0] req_wdata;
    logic        rsp_valid, rsp_ready, rsp_error;
    logic [63:0] rsp_rdata;
    logic [15:0] rd_count, wr_count;

    logic        v0, rdy0, w0, rv0, rr0, re0;
    logic [31:0] a0;
    logic [63:0] d0, rd0;
    logic [15:0] rc0, wc0;

    int          errors = 0;
    int          checks = 0;
    exp_t        sb[$];
    logic [63:0] model_mem [256];
    logic [15:0] rd_exp = 16'd0;
    logic [15:0] wr_exp = 16'd0;

    dmem_responder #(.MEM_WORDS(256), .WAIT_STATES(WS)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
        .rd_count(rd_count), .wr_count(wr_count)
    );

    dmem_responder #(.MEM_WORDS(256), .WAIT_STATES(0)) dut0 (
        .clk(clk), .rst(rst),
        .req_valid(v0), .req_ready(rdy0), .req_write(w0),
        .req_addr(a0), .req_wdata(d0),
        .rsp_valid(rv0), .rsp_ready(rr0),
        .rsp_rdata(rd0), .rsp_error(re0),
        .rd_count(rc0), .wr_count(wc0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", tag, act, exp);
        end
    endtask

    function automatic logic [15:0] sat16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    task automatic do_req(input logic wr, input logic [31:0] addr,
                          input logic [63:0] wd, input int hold);
        exp_t        e;
        int          n;
        int          lat;
        logic [63:0] held;
        e.err   = (addr[2:0] != 3'd0) || (addr[31:3] >= 29'd256);
        e.rdata = 64'd0;
        if (!e.err) begin
            if (wr) begin
                model_mem[addr[10:3]] = wd;
                wr_exp = sat16(wr_exp);
            end else begin
                e.rdata = model_mem[addr[10:3]];
                rd_exp  = sat16(rd_exp);
            end
        end
        sb.push_back(e);

        @(negedge clk);
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd;
        rsp_ready = (hold == 0);
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("accept_timeout", 64'(n < 50), 64'd1);
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        req_valid = 1'b0;
        while (!rsp_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("latency", 64'(lat), 64'(WS + 1));
        e = sb.pop_front();
        check("rdata", rsp_rdata, e.rdata);
        check("error", 64'(rsp_error), 64'(e.err));
        check("rd_count", 64'(rd_count), 64'(rd_exp));
        check("wr_count", 64'(wr_count), 64'(wr_exp));

        if (hold > 0) begin
            held = rsp_rdata;
            req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h18;
            repeat (hold) begin
                @(negedge clk);
                check("bp_valid", 64'(rsp_valid), 64'd1);
                check("bp_stable", rsp_rdata, held);
                check("bp_ready", 64'(req_ready), 64'd0);
            end
            req_valid = 1'b0;
            rsp_ready = 1'b1;
        end
        @(negedge clk);
        check("idle_ready", 64'(req_ready), 64'd1);
        check("rsp_done", 64'(rsp_valid), 64'd0);
    endtask

    initial begin
        rst = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
        v0 = 1'b0; w0 = 1'b0; a0 = '0; d0 = '0; rr0 = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_req_ready", 64'(req_ready), 64'd1);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rdata", rsp_rdata, 64'd0);
        check("rst_counts", {32'd0, rd_count, wr_count}, 64'd0);
        rst = 1'b1;

        // store then load of the same word
        do_req(1'b1, 32'h10, 64'hDEAD_BEEF_0000_0001, 0);
        do_req(1'b0, 32'h10, 64'd0, 0);
        check("st_ld_data", model_mem[2], 64'hDEAD_BEEF_0000_0001);

        // decode errors, with word 0 guarding against address aliasing
        do_req(1'b1, 32'h0, 64'h0123_4567_89AB_CDEF, 0);
        do_req(1'b0, 32'h14, 64'd0, 0);
        do_req(1'b1, 32'h800, 64'hFFFF_0000_FFFF_0000, 0);
        do_req(1'b0, 32'h0, 64'd0, 0);

        // response backpressure with a competing request
        do_req(1'b0, 32'h10, 64'd0, 5);

        for (int i = 0; i < 4; i++) begin
            logic [31:0] ra;
            ra = {21'd0, 8'($urandom_range(3, 255)), 3'd0};
            do_req(1'b1, ra, {$urandom, $urandom}, 0);
            do_req(1'b0, ra, 64'd0, 0);
        end

        // reset while a store to word 1 is waiting
        do_req(1'b1, 32'h08, 64'd5, 0);
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h08; req_wdata = 64'hBAD; rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("pre_rst_wait", 64'(req_ready), 64'd0);
        #1 rst = 1'b0;
        #1;
        check("mid_rst_ready", 64'(req_ready), 64'd1);
        check("mid_rst_valid", 64'(rsp_valid), 64'd0);
        check("mid_rst_err", 64'(rsp_error), 64'd0);
        check("mid_rst_rdata", rsp_rdata, 64'd0);
        check("mid_rst_counts", {32'd0, rd_count, wr_count}, 64'd0);
        rd_exp = 16'd0;
        wr_exp = 16'd0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        do_req(1'b0, 32'h08, 64'd0, 0);

        // write counter saturation
        @(negedge clk);
        force dut.wr_cnt_q = 16'hFFFE;
        #1 release dut.wr_cnt_q;
        wr_exp = 16'hFFFE;
        for (int i = 0; i < 3; i++) begin
            do_req(1'b1, 32'h20, 64'(i), 0);
        end
        check("wr_sat", 64'(wr_count), 64'hFFFF);

        // zero wait states: one-cycle latency, accept every other edge
        @(negedge clk);
        v0 = 1'b1; w0 = 1'b1; a0 = 32'h18; d0 = 64'h77; rr0 = 1'b1;
        check("ws0_idle_ready", 64'(rdy0), 64'd1);
        @(posedge clk);
        @(negedge clk);
        check("ws0_latency", 64'(rv0), 64'd1);
        check("ws0_busy", 64'(rdy0), 64'd0);
        check("ws0_err", 64'(re0), 64'd0);
        @(posedge clk);
        @(negedge clk);
        check("ws0_back_idle", 64'(rdy0), 64'd1);
        check("ws0_rsp_done", 64'(rv0), 64'd0);
        @(posedge clk);
        @(negedge clk);
        v0 = 1'b0;
        check("ws0_second_accept", 64'(rv0), 64'd1);
        check("ws0_wr_count", 64'(wc0), 64'd2);
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
